// File: rtl/cic_dec_ctrl.sv
// Sequencer and output buffer for the CIC decimation filter: applies configuration
// through a one-cycle clear, discards settling outputs, buffers samples into a
// valid/ready stream. Define CIC_DEC_CTRL_FIFO_EN for a FIFO_DEPTH-entry buffer.
module cic_dec_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEC_W          = 2,
  parameter int SETTLE_SAMPLES = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_enable,
  input  logic [DEC_W-1:0]      cfg_dec_factor,
  output logic                  cic_clear,
  output logic                  cic_enable,
  output logic [DEC_W-1:0]      cic_dec_factor,
  input  logic                  cic_out_valid,
  input  logic [DATA_WIDTH-1:0] cic_out_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  typedef enum logic [1:0] {IDLE, CLEAR, SETTLE, RUN} state_t;

  localparam int CNT_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEC_W-1:0] dec_q, dec_d;
  logic             overflow_q, overflow_d;

  logic cfg_accept, strobe_run, pop, push, drop, full;

  assign cfg_ready      = (state_q != CLEAR);
  assign cic_clear      = (state_q == CLEAR);
  assign cic_enable     = (state_q == SETTLE) || (state_q == RUN);
  assign busy           = (state_q == CLEAR) || (state_q == SETTLE);
  assign cic_dec_factor = dec_q;
  assign overflow       = overflow_q;

  assign cfg_accept = cfg_valid && cfg_ready;
  // A config accept aborts the stream, so a strobe arriving that cycle is dropped.
  assign strobe_run = cic_out_valid && (state_q == RUN) && !cfg_accept;
  assign pop        = m_valid && m_ready;
  assign push       = strobe_run && (!full || pop);
  assign drop       = strobe_run && full && !pop;

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    if (cfg_accept) begin
      dec_d   = cfg_dec_factor;
      state_d = cfg_enable ? CLEAR : IDLE;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_d   = CNT_W'(SETTLE_SAMPLES);
          state_d = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
        end
        SETTLE: begin
          if (cic_out_valid) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dec_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dec_q      <= dec_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef CIC_DEC_CTRL_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]           fill_q, fill_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  assign full    = (fill_q == (AW+1)'(FIFO_DEPTH));
  assign m_valid = (fill_q != '0);
  assign m_data  = m_valid ? mem_q[rd_q] : '0;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    fill_d = fill_q;
    if (cfg_accept) begin
      wr_d   = '0;
      rd_d   = '0;
      fill_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   fill_d = fill_q + (AW+1)'(1);
        2'b01:   fill_d = fill_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
    end
  end

  // NOTE: storage is not reset; fill_q alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= cic_out_data;
  end
`else
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign full    = valid_q;
  assign m_valid = valid_q;
  assign m_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (cfg_accept) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d = 1'b1;
      data_d  = cic_out_data;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
`endif

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed self-checking bench for cic_dec_ctrl; expectations adapt to the buffer
// depth selected by CIC_DEC_CTRL_FIFO_EN.
module tb_cic_dec_ctrl;

`ifdef CIC_DEC_CTRL_FIFO_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       cfg_valid, cfg_ready, cfg_enable;
  logic [1:0] cfg_dec_factor;
  logic       cic_clear, cic_enable;
  logic [1:0] cic_dec_factor;
  logic       cic_out_valid;
  logic [7:0] cic_out_data;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic       busy, overflow, overflow_clr;

  int checks = 0;
  int errors = 0;

  cic_dec_ctrl #(
    .DATA_WIDTH(8), .DEC_W(2), .SETTLE_SAMPLES(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_enable(cfg_enable),
    .cfg_dec_factor(cfg_dec_factor),
    .cic_clear(cic_clear), .cic_enable(cic_enable), .cic_dec_factor(cic_dec_factor),
    .cic_out_valid(cic_out_valid), .cic_out_data(cic_out_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs set before step() are sampled at that edge; outputs are read 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    cic_out_valid = 1'b1;
    cic_out_data  = d;
    step();
    cic_out_valid = 1'b0;
  endtask

  task automatic configure(input logic en, input logic [1:0] dec);
    cfg_valid      = 1'b1;
    cfg_enable     = en;
    cfg_dec_factor = dec;
    step();
    cfg_valid      = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; cfg_valid = 1'b0; cfg_enable = 1'b0; cfg_dec_factor = '0;
    cic_out_valid = 1'b0; cic_out_data = '0; m_ready = 1'b0; overflow_clr = 1'b0;
    step();
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_clear", cic_clear, 0);
    check("rst_enable", cic_enable, 0);
    check("rst_dec", cic_dec_factor, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy_ovf", {busy, overflow}, 0);
    step();
    resetn = 1'b1;
    step();

    // IDLE ignores strobes
    strobe(8'hAA);
    check("idle_no_valid", m_valid, 0);

    // T2: configure, one-cycle clear, settling discards
    check("t2_cfg_ready_pre", cfg_ready, 1);
    configure(1'b1, 2'd2);
    check("t2_clear", cic_clear, 1);
    check("t2_dec", cic_dec_factor, 2);
    check("t2_clear_state", {cfg_ready, cic_enable, busy}, 3'b001);
    step();
    check("t2_clear_1cyc", cic_clear, 0);
    check("t2_settle", {cic_enable, busy}, 2'b11);
    strobe(8'h11);
    strobe(8'h22);
    check("t2_busy_after2", busy, 1);
    strobe(8'h33);
    check("t2_run", {busy, cic_enable, m_valid}, 3'b010);
    strobe(8'h44);
    check("t2_m_valid", m_valid, 1);
    check("t2_m_data", m_data, 8'h44);
    step();
    check("t2_hold", {m_valid, m_data}, {1'b1, 8'h44});
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("t2_popped", m_valid, 0);

    // T3: backpressure and overflow
    for (int i = 1; i <= 5; i++) strobe(8'(i));
    check("t3_head", {m_valid, m_data}, {1'b1, 8'h01});
    check("t3_overflow", overflow, 1);
    m_ready = 1'b1;
    for (int i = 1; i <= D; i++) begin
      check("t3_drain", {m_valid, m_data}, {1'b1, 8'(i)});
      step();
    end
    check("t3_lost", m_valid, 0);
    m_ready = 1'b0;
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("t3_ovf_clr", overflow, 0);

    // T4: full buffer with push and pop in the same cycle
    for (int i = 0; i < D; i++) strobe(8'(8'h10 + i));
    check("t4_full_head", m_data, 8'h10);
    m_ready = 1'b1;
    strobe(8'h7F);
    check("t4_no_ovf", overflow, 0);
    for (int i = 1; i < D; i++) begin
      check("t4_order", {m_valid, m_data}, {1'b1, 8'(8'h10 + i)});
      step();
    end
    check("t4_last", {m_valid, m_data}, {1'b1, 8'h7F});
    step();
    check("t4_empty", m_valid, 0);
    m_ready = 1'b0;

    // T5: reconfig mid-stream with a strobe on the accept cycle
    strobe(8'h21);
    strobe(8'h22);
    check("t5_pre_valid", m_valid, 1);
    overflow_clr = 1'b1;
    cic_out_valid = 1'b1;
    cic_out_data  = 8'h99;
    configure(1'b1, 2'd3);
    cic_out_valid = 1'b0;
    overflow_clr = 1'b0;
    check("t5_flush", m_valid, 0);
    check("t5_clear", {cic_clear, busy, cic_dec_factor}, {1'b1, 1'b1, 2'd3});
    check("t5_ovf_cleared", overflow, 0);
    step();
    check("t5_settle", {cic_clear, busy}, 2'b01);
    strobe(8'h01);
    strobe(8'h02);
    check("t5_busy", {busy, m_valid}, 2'b10);
    strobe(8'h03);
    check("t5_run", {busy, m_valid}, 2'b00);
    strobe(8'h55);
    check("t5_first", {m_valid, m_data}, {1'b1, 8'h55});

    // T6: overflow_clr loses to a same-cycle overflow, then stop
    for (int i = 1; i < D; i++) strobe(8'(8'h60 + i));
    overflow_clr = 1'b1;
    strobe(8'hEE);
    overflow_clr = 1'b0;
    check("t6_ovf_priority", overflow, 1);
    check("t6_oldest_kept", m_data, 8'h55);
    configure(1'b0, 2'd1);
    check("t6_stop", {cic_enable, m_valid, busy, cfg_ready}, 4'b0001);
    check("t6_dec", cic_dec_factor, 1);
    strobe(8'h77);
    strobe(8'h78);
    check("t6_ignored", m_valid, 0);

    // T1: reset mid-RUN with m_valid=1
    configure(1'b1, 2'd2);
    step();
    strobe(8'h01); strobe(8'h02); strobe(8'h03);
    strobe(8'h5A);
    check("t1_pre", {m_valid, overflow}, 2'b11);
    #2;
    resetn = 1'b0;
    #1;
    check("t1_outputs", {cfg_ready, cic_clear, cic_enable, m_valid, busy, overflow},
          6'b100000);
    check("t1_data_dec", {m_data, cic_dec_factor}, 10'd0);
    step();
    resetn = 1'b1;
    step();
    check("t1_idle", {cic_clear, cic_enable, busy}, 3'b000);
    strobe(8'h33);
    check("t1_idle_ignore", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
